// File: rtl/opb_register_bank_ppc2simulink.sv
// ---------------------------------------------------------------------------
// opb_register_bank_ppc2simulink
//
// OPB slave register bank that exposes N_REGS 32-bit control/status words
// from the PowerPC bus to Simulink user logic on the same clock.
//
// Each word is one of three kinds:
//   read/write  - stored value, byte-enable writes, read back by software
//   pulse       - byte-enabled bits are presented for exactly one cycle
//   read-only   - software reads user_data_in; writes are acked and dropped
//
// Ports
//   OPB_Clk, OPB_Rst_n      clock, synchronous active-low reset
//   OPB_ABus/BE/DBus/RNW    OPB address, byte enables, write data, direction
//   OPB_select, OPB_seqAddr transfer request (seqAddr unused)
//   Sl_DBus, Sl_xferAck     read data (zero outside ack), one-cycle ack
//   Sl_errAck/retry/toutSup tied low
//   user_data_out           word i at [32i+31:32i]
//   user_data_in            status words for read-only slots
//   user_wr_strobe          one-cycle pulse per written word
// ---------------------------------------------------------------------------
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0]       C_BASEADDR   = 32'h01060400,
  parameter logic [31:0]       C_HIGHADDR   = 32'h010604FF,
  parameter int                C_OPB_AWIDTH = 32,
  parameter int                C_OPB_DWIDTH = 32,
  parameter int                N_REGS       = 4,
  parameter logic [N_REGS-1:0] PULSE_MASK   = '0,
  parameter logic [N_REGS-1:0] RO_MASK      = '0
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst_n,
  input  logic [0:31]              OPB_ABus,
  input  logic [0:3]               OPB_BE,
  input  logic [0:31]              OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:31]              Sl_DBus,
  output logic                     Sl_xferAck,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic [N_REGS*32-1:0]     user_data_out,
  input  logic [N_REGS*32-1:0]     user_data_in,
  output logic [N_REGS-1:0]        user_wr_strobe
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [N_REGS-1:0][31:0]  regs_q, regs_d;
  logic [N_REGS-1:0]        strobe_q, strobe_d;
  logic [31:0]              rdata_q, rdata_d;

  logic [31:0] addr_w;
  logic [31:0] wdata_w;
  logic [31:0] be_mask;
  logic [31:0] offset;
  logic [31:0] word_num;
  logic        hit;
  logic        take;

  // OPB numbers bit 0 as the MSB; positional assignment lands DBus[0] on
  // bit 31 of the user word, which is the required mapping.
  assign addr_w  = OPB_ABus;
  assign wdata_w = OPB_DBus;

  assign hit      = OPB_select && (addr_w >= C_BASEADDR) && (addr_w <= C_HIGHADDR);
  assign offset   = addr_w - C_BASEADDR;
  // Byte-lane bits of the address are ignored.
  assign word_num = {2'b00, offset[31:2]};

  // A transfer is only decoded from IDLE, so the ack cycle itself can never
  // start a second transfer and acks are always separated by a gap.
  assign take = (state_q == S_IDLE) && hit;

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < 4; b++) begin
      be_mask[31-8*b -: 8] = {8{OPB_BE[b]}};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d  = '0;
    strobe_d = '0;
    for (int i = 0; i < N_REGS; i++) begin
      // Pulse words fall back to zero one edge after any write; read-only
      // slots hold nothing locally.
      regs_d[i] = (PULSE_MASK[i] || RO_MASK[i]) ? 32'h0 : regs_q[i];
      if (take && (word_num == 32'(i))) begin
        if (OPB_RNW) begin
          rdata_d = RO_MASK[i] ? user_data_in[32*i +: 32] : regs_q[i];
        end else if (!RO_MASK[i]) begin
          regs_d[i]   = (regs_q[i] & ~be_mask) | (wdata_w & be_mask);
          strobe_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state_q  <= S_IDLE;
      regs_q   <= '0;
      strobe_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
    end
  end

  assign Sl_xferAck     = (state_q == S_ACK);
  // rdata_q is only loaded on the decode edge and cleared on the next one,
  // so the bus sees data exactly during the ack cycle.
  assign Sl_DBus        = rdata_q;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;
  assign user_data_out  = regs_q;
  assign user_wr_strobe = strobe_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, OPB_seqAddr, offset[1:0],
                       (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32)};

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01060400;
  localparam logic [31:0] HIGH = 32'h010604FF;
  localparam logic [3:0]  PMASK = 4'b0100;
  localparam logic [3:0]  RMASK = 4'b1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  abus;
  logic [3:0]   be;
  logic [31:0]  dbus;
  logic         rnw;
  logic         sel;
  logic         seqa;
  logic [31:0]  sl_dbus;
  logic         ack, errack, retry, toutsup;
  logic [127:0] udo;
  logic [127:0] uin;
  logic [3:0]   strobe;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .N_REGS(4), .PULSE_MASK(PMASK), .RO_MASK(RMASK)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be),
    .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqa),
    .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(errack), .Sl_retry(retry),
    .Sl_toutSup(toutsup), .user_data_out(udo), .user_data_in(uin),
    .user_wr_strobe(strobe)
  );

  // Reference model: transfer-level rules evaluated once per clock.
  logic [31:0] m_words [4];
  logic        m_ack;
  logic [31:0] m_dbus;
  logic [3:0]  m_strobe;

  logic [31:0] n_words [4];
  logic        n_acc;
  logic [31:0] n_rd;
  logic [3:0]  n_stb;
  logic [31:0] n_mask;
  int unsigned n_idx;

  always_comb begin
    n_acc  = 1'b0;
    n_rd   = 32'h0;
    n_stb  = 4'h0;
    n_idx  = 0;
    n_mask = 32'h0;
    for (int k = 0; k < 4; k++) begin
      n_words[k] = PMASK[k] ? 32'h0 : m_words[k];
      if (be[k]) n_mask = n_mask | (32'hFF << (8 * k));
    end
    if (!m_ack && sel && abus >= BASE && abus <= HIGH) begin
      n_acc = 1'b1;
      n_idx = (abus - BASE) / 4;
      if (rnw) begin
        if (n_idx < 4) n_rd = RMASK[n_idx] ? uin[n_idx*32 +: 32] : m_words[n_idx];
      end else if (n_idx < 4 && !RMASK[n_idx]) begin
        n_words[n_idx] = (m_words[n_idx] & ~n_mask) | (dbus & n_mask);
        n_stb[n_idx]   = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_words  <= '{default: 32'h0};
      m_ack    <= 1'b0;
      m_dbus   <= 32'h0;
      m_strobe <= 4'h0;
    end else begin
      m_words  <= n_words;
      m_ack    <= n_acc;
      m_dbus   <= n_rd;
      m_strobe <= n_stb;
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic r, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    @(negedge clk);
    abus = a; rnw = r; dbus = d; be = b; sel = 1'b1;
    @(posedge clk);
    #1;
    sel = 1'b0;
  endtask

  int acks;

  initial begin
    rst_n = 1'b0; sel = 1'b1; abus = BASE; rnw = 1'b0; dbus = 32'hDEADBEEF;
    be = 4'hF; seqa = 1'b0; uin = '0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          check("cmp_ack", {127'h0, ack}, {127'h0, m_ack});
          check("cmp_dbus", {96'h0, sl_dbus}, {96'h0, m_dbus});
          check("cmp_strobe", {124'h0, strobe}, {124'h0, m_strobe});
          check("cmp_udo", udo, {m_words[3], m_words[2], m_words[1], m_words[0]});
          check("cmp_ties", {125'h0, errack, retry, toutsup}, 128'h0);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {127'h0, ack}, 128'h0);
    check("rst_dbus", {96'h0, sl_dbus}, 128'h0);
    check("rst_udo", udo, 128'h0);
    check("rst_strobe", {124'h0, strobe}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1; sel = 1'b0;
    chk_en = 1'b1;

    // Byte-enable writes to word 1
    xfer(BASE + 32'h4, 1'b0, 32'hDEADBEEF, 4'b1111);
    check("wr1_ack", {127'h0, ack}, 128'h1);
    check("wr1_strobe", {124'h0, strobe}, 128'h2);
    check("wr1_word", {96'h0, udo[63:32]}, {96'h0, 32'hDEADBEEF});
    xfer(BASE + 32'h4, 1'b0, 32'h11223344, 4'b0101);
    check("wr2_word", {96'h0, udo[63:32]}, {96'h0, 32'hDE22BE44});
    check("wr2_strobe", {124'h0, strobe}, 128'h2);

    // Readback, then out-of-range word inside the window
    xfer(BASE + 32'h4, 1'b1, 32'h0, 4'hF);
    check("rd1_ack", {127'h0, ack}, 128'h1);
    check("rd1_dbus", {96'h0, sl_dbus}, {96'h0, 32'hDE22BE44});
    xfer(32'h01060410, 1'b1, 32'h0, 4'hF);
    check("rd4_ack", {127'h0, ack}, 128'h1);
    check("rd4_dbus", {96'h0, sl_dbus}, 128'h0);

    // Pulse word 2
    xfer(BASE + 32'h8, 1'b0, 32'h00000001, 4'hF);
    check("pulse_hi", {127'h0, udo[64]}, 128'h1);
    @(posedge clk);
    #1;
    check("pulse_lo", {96'h0, udo[95:64]}, 128'h0);
    xfer(BASE + 32'h8, 1'b1, 32'h0, 4'hF);
    check("pulse_rd", {96'h0, sl_dbus}, 128'h0);

    // Read-only word 3
    uin = {32'hCAFEF00D, 96'h0};
    xfer(BASE + 32'hC, 1'b1, 32'h0, 4'hF);
    check("ro_rd", {96'h0, sl_dbus}, {96'h0, 32'hCAFEF00D});
    xfer(BASE + 32'hC, 1'b0, 32'hFFFFFFFF, 4'hF);
    check("ro_wr_ack", {127'h0, ack}, 128'h1);
    check("ro_wr_strobe", {124'h0, strobe}, 128'h0);
    xfer(BASE + 32'hC, 1'b1, 32'h0, 4'hF);
    check("ro_rd2", {96'h0, sl_dbus}, {96'h0, 32'hCAFEF00D});

    // Randomized traffic, including resets and out-of-window addresses
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 39) != 0);
      sel   = ($urandom_range(0, 2) != 0);
      rnw   = $urandom_range(0, 1) == 1;
      dbus  = $urandom;
      be    = 4'($urandom_range(0, 15));
      uin   = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: abus = BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
        6:       abus = BASE + 32'hFC;
        7:       abus = BASE - 32'h4;
        8:       abus = HIGH + 32'h1;
        default: abus = $urandom;
      endcase
    end
    @(negedge clk);
    rst_n = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);

    // Select held high: acks every other cycle
    abus = BASE; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    acks = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
    end
    sel = 1'b0;
    check("b2b_acks", 128'(acks), 128'd3);

    // Reset asserted during an ack cycle
    xfer(BASE, 1'b0, 32'h12345678, 4'hF);
    check("rm_word0", {96'h0, udo[31:0]}, {96'h0, 32'h12345678});
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rm_ack", {127'h0, ack}, 128'h0);
    check("rm_udo", udo, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Parametrised OPB slave register bank between the PowerPC OPB bus and Simulink user logic, for control/status registers on the F-engine. Generalises the single 32-bit software-to-user register to N_REGS words with per-word mode (read/write, self-clearing pulse, or read-only status from user logic), byte-enable writes, software readback and per-word write strobes. Single clock domain: user logic runs on OPB_Clk.

## Interface
Parameters:
- C_BASEADDR, 32'h01060400, first byte address of the bank window
- C_HIGHADDR, 32'h010604FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width (only 32 supported)
- C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
- N_REGS, 4, number of 32-bit words, 1..64; must satisfy 4*N_REGS <= C_HIGHADDR-C_BASEADDR+1
- PULSE_MASK, 0, N_REGS-bit; bit i=1 makes word i self-clearing
- RO_MASK, 0, N_REGS-bit; bit i=1 makes word i read-only, sourced from user_data_in; RO overrides PULSE

Ports:
- OPB_Clk  in  1  bus and user clock
- OPB_Rst_n  in  1  reset; one clock; reset is synchronous and active-low
- OPB_ABus  in  [0:31]  byte address
- OPB_BE  in  [0:3]  byte enables, BE[0] covers DBus[0:7]
- OPB_DBus  in  [0:31]  write data, bit 0 = MSB
- OPB_RNW  in  1  1=read, 0=write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data, zero except during read ack
- Sl_xferAck  out  1  one-cycle transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_out  out  N_REGS*32  word i at [32i+31:32i], user bit 31 = DBus[0]
- user_data_in  in  N_REGS*32  status words, used only where RO_MASK bit set
- user_wr_strobe  out  N_REGS  one-cycle pulse when word i is written

## Operation
- Decode: hit = OPB_select & (C_BASEADDR <= ABus <= C_HIGHADDR); idx = (ABus - C_BASEADDR) >> 2; ABus[30:31] ignored.
- FSM: IDLE -> ACK when hit & !Sl_xferAck; ACK -> IDLE unconditionally (ACK lasts exactly one cycle). Non-hit select stays in IDLE, no response.
- Write (RNW=0), idx < N_REGS, word RW: on the ACK-entry edge each byte with BE set is loaded (BE[0]->bits 31:24 … BE[3]->7:0); unset bytes keep value. user_wr_strobe[idx] pulses 1 cycle, even if BE=0000.
- Write to PULSE word: byte-enabled bits load for one cycle, then the whole word returns to 0 on the next edge; strobe pulses.
- Write to RO word or idx >= N_REGS: acked, no state change, no strobe.
- Read (RNW=1): Sl_DBus = word idx (RW: stored value; PULSE: current value, normally 0; RO: user_data_in sampled at the decode edge); idx >= N_REGS returns 0. No strobe.
- Reset (OPB_Rst_n=0 at an edge): all words 0, FSM IDLE, Sl_xferAck 0, Sl_DBus 0, user_wr_strobe 0. Reset during ACK drops the ack; a write whose ACK edge coincides with reset is lost.

## Timing
- Select sampled high at edge N (IDLE) -> Sl_xferAck high from edge N to N+1 exactly; write data visible on user_data_out from edge N; user_wr_strobe high same cycle as Sl_xferAck.
- Read data on Sl_DBus only while Sl_xferAck=1, else 0.
- Select held high after ack: next transfer decoded at edge N+1 (IDLE), acked N+2; max one transfer per 2 cycles, never two consecutive ack cycles.
- PULSE word nonzero for exactly one cycle (edge N to N+1).
- All outputs registered; no combinational path from OPB inputs to any output.

## Test plan
- Reset: drive data on bus, assert OPB_Rst_n=0 for 3 cycles -> user_data_out=0, Sl_xferAck=0, Sl_DBus=0, strobes 0.
- Byte-enable write: N_REGS=4, write 0xDEADBEEF BE=1111 to word 1, then 0x11223344 BE=0101 -> word 1 = 0xDE22BE44, two strobe pulses on bit 1, ack 1 cycle after each select.
- Readback: read word 1 -> Sl_DBus=0xDE22BE44 during ack only; read 0x01060410 (idx 4) -> acked, 0x00000000.
- Pulse: PULSE_MASK=4'b0100, write 0x00000001 to word 2 -> user bits [64]=1 for exactly one cycle, readback next transfer 0.
- Read-only: RO_MASK=4'b1000, user_data_in word 3=0xCAFEF00D -> read returns it; write 0xFFFFFFFF acked, no strobe, readback still 0xCAFEF00D.
- Back-to-back / reset mid-op: select held high for 6 cycles -> acks every other cycle; drop reset in ACK cycle -> Sl_xferAck 0 next cycle, words 0.
